// File: rtl/minmax_reduce.sv
// Purpose : streaming unsigned min/max reduction, one result word per frame of WIDTH-bit beats.
// Latency : result visible the cycle after the s_last beat is accepted; one beat per cycle sustained.
// Backpr. : s_ready = !m_valid | m_ready; a held result freezes the accumulator until it is taken.
//
// Ports:
//   clk, rst_n                      rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last   input beat stream; s_mode (0=min, 1=max) sampled on first beat
//   m_valid/m_ready                 result handshake
//   m_data                          frame extreme
//   m_count                         beats in frame, saturating at 2^CNTW-1
//   m_index                         0-based winner position (only when MINMAX_REDUCE_INDEX_EN is defined)
//
// Optional feature: define MINMAX_REDUCE_INDEX_EN to add the winner-index tracker and m_index port.

module minmax_reduce #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             s_mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNTW-1:0]  m_count
`ifdef MINMAX_REDUCE_INDEX_EN
    ,
    output logic [CNTW-1:0]  m_index
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [CNTW-1:0]  m_count_q, m_count_d;
`ifdef MINMAX_REDUCE_INDEX_EN
    logic [CNTW-1:0]  idx_q, idx_d;
    logic [CNTW-1:0]  m_index_q, m_index_d;
`endif

    logic s_fire;
    logic beat_win;

    // Accepting a beat is only blocked by an unconsumed result.
    assign s_ready = !m_valid_q || m_ready;
    assign s_fire  = s_valid && s_ready;

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_count = m_count_q;
`ifdef MINMAX_REDUCE_INDEX_EN
    assign m_index = m_index_q;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;
        // A consumed result drops unless a new one loads below in the same cycle.
        m_valid_d = m_valid_q && !m_ready;
        beat_win  = 1'b0;
`ifdef MINMAX_REDUCE_INDEX_EN
        idx_d     = idx_q;
        m_index_d = m_index_q;
`endif

        if (s_fire) begin
            if (state_q == IDLE) begin
                acc_d  = s_data;
                mode_d = s_mode;
                cnt_d  = CNT_ONE;
`ifdef MINMAX_REDUCE_INDEX_EN
                idx_d  = '0;
`endif
            end else begin
                // Strict comparison: a tie keeps the earlier word.
                beat_win = mode_q ? (s_data > acc_q) : (s_data < acc_q);
                if (beat_win) begin
                    acc_d = s_data;
`ifdef MINMAX_REDUCE_INDEX_EN
                    // The pre-increment count is this beat's 0-based position,
                    // already clamped at CNT_MAX once the counter saturates.
                    idx_d = cnt_q;
`endif
                end
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
            end

            if (s_last) begin
                m_valid_d = 1'b1;
                m_data_d  = acc_d;
                m_count_d = cnt_d;
`ifdef MINMAX_REDUCE_INDEX_EN
                m_index_d = idx_d;
`endif
                state_d   = IDLE;
            end else begin
                state_d   = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
`ifdef MINMAX_REDUCE_INDEX_EN
            idx_q     <= '0;
            m_index_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
`ifdef MINMAX_REDUCE_INDEX_EN
            idx_q     <= idx_d;
            m_index_q <= m_index_d;
`endif
        end
    end

endmodule

// File: tb/tb_minmax_reduce.sv
// Directed bench for minmax_reduce: a 32/8 instance (a_*) and a 32/2 instance (b_*) for counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// m_index checks are compiled only when MINMAX_REDUCE_INDEX_EN is defined.

module tb_minmax_reduce;

    logic        clk;
    logic        rst_n;

    logic        a_s_valid, a_s_ready, a_s_last, a_s_mode;
    logic [31:0] a_s_data;
    logic        a_m_valid, a_m_ready;
    logic [31:0] a_m_data;
    logic [7:0]  a_m_count;

    logic        b_s_valid, b_s_ready, b_s_last, b_s_mode;
    logic [31:0] b_s_data;
    logic        b_m_valid, b_m_ready;
    logic [31:0] b_m_data;
    logic [1:0]  b_m_count;

`ifdef MINMAX_REDUCE_INDEX_EN
    logic [7:0]  a_m_index;
    logic [1:0]  b_m_index;
`endif

    int vectors;
    int miscompares;

    minmax_reduce #(.WIDTH(32), .CNTW(8)) u_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (a_s_valid),
        .s_ready (a_s_ready),
        .s_data  (a_s_data),
        .s_last  (a_s_last),
        .s_mode  (a_s_mode),
        .m_valid (a_m_valid),
        .m_ready (a_m_ready),
        .m_data  (a_m_data),
        .m_count (a_m_count)
`ifdef MINMAX_REDUCE_INDEX_EN
        ,
        .m_index (a_m_index)
`endif
    );

    minmax_reduce #(.WIDTH(32), .CNTW(2)) u_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (b_s_valid),
        .s_ready (b_s_ready),
        .s_data  (b_s_data),
        .s_last  (b_s_last),
        .s_mode  (b_s_mode),
        .m_valid (b_m_valid),
        .m_ready (b_m_ready),
        .m_data  (b_m_data),
        .m_count (b_m_count)
`ifdef MINMAX_REDUCE_INDEX_EN
        ,
        .m_index (b_m_index)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [31:0] d, input logic last, input logic mode);
        a_s_valid = 1'b1;
        a_s_data  = d;
        a_s_last  = last;
        a_s_mode  = mode;
    endtask

    task automatic b_beat(input logic [31:0] d, input logic last);
        b_s_valid = 1'b1;
        b_s_data  = d;
        b_s_last  = last;
        b_s_mode  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_s_mode = 1'b0; a_m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_s_mode = 1'b0; b_m_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_s_ready", a_s_ready, 1);
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_m_data", a_m_data, 0);
        chk("rst_m_count", a_m_count, 0);
`ifdef MINMAX_REDUCE_INDEX_EN
        chk("rst_m_index", a_m_index, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Min frame 5,3,9,3: the first 3 (position 1) wins the tie
        a_m_ready = 1'b1;
        a_beat(5, 0, 0); tick();
        a_beat(3, 0, 0); tick();
        a_beat(9, 0, 0); tick();
        a_beat(3, 1, 0);
        chk("min_s_ready", a_s_ready, 1);
        tick();
        a_s_valid = 1'b0;
        chk("min_m_valid", a_m_valid, 1);
        chk("min_m_data", a_m_data, 3);
        chk("min_m_count", a_m_count, 4);
`ifdef MINMAX_REDUCE_INDEX_EN
        chk("min_m_index", a_m_index, 1);
`endif
        tick();
        chk("min_m_valid_drop", a_m_valid, 0);

        // Max frame, mode sampled on first beat only, unsigned compare
        a_beat(32'h0000_0010, 0, 1); tick();
        a_beat(32'hFFFF_FFFF, 0, 0); tick();
        a_beat(32'h7FFF_FFFF, 1, 0); tick();
        a_s_valid = 1'b0;
        chk("max_m_valid", a_m_valid, 1);
        chk("max_m_data", a_m_data, 32'hFFFF_FFFF);
        chk("max_m_count", a_m_count, 3);
`ifdef MINMAX_REDUCE_INDEX_EN
        chk("max_m_index", a_m_index, 1);
`endif
        tick();
        chk("max_m_valid_drop", a_m_valid, 0);

        // Back-to-back single-beat frames 7, 2, 11
        a_beat(7, 1, 0); tick();
        chk("b2b0_m_valid", a_m_valid, 1);
        chk("b2b0_m_data", a_m_data, 7);
        chk("b2b0_m_count", a_m_count, 1);
        chk("b2b0_s_ready", a_s_ready, 1);
        a_beat(2, 1, 1); tick();
        chk("b2b1_m_valid", a_m_valid, 1);
        chk("b2b1_m_data", a_m_data, 2);
        chk("b2b1_s_ready", a_s_ready, 1);
        a_beat(11, 1, 0); tick();
        chk("b2b2_m_valid", a_m_valid, 1);
        chk("b2b2_m_data", a_m_data, 11);
        chk("b2b2_s_ready", a_s_ready, 1);
        a_s_valid = 1'b0;
        tick();
        chk("b2b_m_valid_drop", a_m_valid, 0);

        // Backpressure: result 20 held for 10 cycles while beat 99 waits
        a_m_ready = 1'b0;
        a_beat(20, 1, 0); tick();
        a_beat(99, 1, 0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_s_ready", a_s_ready, 0);
            chk("hold_m_valid", a_m_valid, 1);
            chk("hold_m_data", a_m_data, 20);
            tick();
        end
        a_m_ready = 1'b1;
        #1;
        chk("release_s_ready", a_s_ready, 1);
        tick();
        a_s_valid = 1'b0;
        chk("release_m_valid", a_m_valid, 1);
        chk("release_m_data", a_m_data, 99);
        chk("release_m_count", a_m_count, 1);
        tick();
        chk("release_m_valid_drop", a_m_valid, 0);

        // Reset with a result pending: m_valid drops without a clock edge
        a_m_ready = 1'b0;
        a_beat(33, 1, 0); tick();
        a_s_valid = 1'b0;
        chk("pend_m_valid", a_m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("pend_rst_m_valid", a_m_valid, 0);
        chk("pend_rst_m_data", a_m_data, 0);
        chk("pend_rst_s_ready", a_s_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();

        // Reset after 2 beats of a max frame: partial frame is discarded
        a_m_ready = 1'b1;
        a_beat(60, 0, 1); tick();
        a_beat(70, 0, 1); tick();
        a_s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", a_m_valid, 0);
        #2;
        rst_n = 1'b1;
        tick();
        a_beat(4, 0, 0); tick();
        a_beat(1, 1, 0); tick();
        a_s_valid = 1'b0;
        chk("post_rst_m_valid", a_m_valid, 1);
        chk("post_rst_m_data", a_m_data, 1);
        chk("post_rst_m_count", a_m_count, 2);
`ifdef MINMAX_REDUCE_INDEX_EN
        chk("post_rst_m_index", a_m_index, 1);
`endif

        // CNTW=2: 6-beat min frame, minimum on the last beat
        b_beat(9, 0); tick();
        b_beat(8, 0); tick();
        b_beat(8, 0); tick();
        b_beat(8, 0); tick();
        b_beat(8, 0); tick();
        b_beat(2, 1); tick();
        b_s_valid = 1'b0;
        chk("sat_m_valid", b_m_valid, 1);
        chk("sat_m_data", b_m_data, 2);
        chk("sat_m_count", b_m_count, 3);
`ifdef MINMAX_REDUCE_INDEX_EN
        chk("sat_m_index", b_m_index, 3);
`endif
        tick();
        chk("sat_m_valid_drop", b_m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
